// File: rtl/snes_pad_reader.sv
// -----------------------------------------------------------------------------
// snes_pad_reader
//
// Polls an SNES controller: raises the latch, clocks out 16 serial button
// bits, and presents a registered active-high button vector. All timing
// comes from counters on the core clock; no divided clocks are generated.
// One frame lasts 33*CLK_DIV+1 cycles and a frame starts every POLL_DIV
// cycles while enable is high.
//
// Optional feature (macro SNES_PAD_DEBOUNCE_EN):
//   button_state only changes, and state_valid only pulses, when two
//   consecutive raw frames agree.
//
// Ports:
//   clock            in   core clock (33.33 MHz)
//   reset_n          in   asynchronous active-low reset
//   enable           in   polling enable; low holds the poll counter at 0
//   controller_data  in   serial pad data, active-low (0 = pressed)
//   controller_clock out  pad shift clock, idles high
//   controller_latch out  pad latch pulse, active-high
//   button_state     out  [15:0] bit n = button n pressed, registered
//   state_valid      out  one-cycle pulse when button_state is updated
//   busy             out  high while a frame is in progress
// -----------------------------------------------------------------------------
module snes_pad_reader #(
   parameter int unsigned CLK_DIV  = 200,
   parameter int unsigned POLL_DIV = 555555
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        controller_data,
   output logic        controller_clock,
   output logic        controller_latch,
   output logic [15:0] button_state,
   output logic        state_valid,
   output logic        busy
);

   localparam logic [19:0] POLL_LAST  = 20'(POLL_DIV - 1);
   localparam logic [16:0] DIV_LAST   = 17'(CLK_DIV - 1);
   localparam logic [16:0] LATCH_LAST = 17'(2 * CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_GAP,
      S_LOW,
      S_HIGH,
      S_DONE
   } state_t;

   state_t      state_q;
   logic [19:0] poll_q, poll_d;
   logic [16:0] phase_q;
   logic [3:0]  bit_q;
   logic [15:0] shift_q;
   logic [1:0]  sync_q;
   logic        data_s;
   logic        latch_q;
   logic        clk_q;
   logic [15:0] button_q;
   logic        valid_q;
   logic        busy_q;
`ifdef SNES_PAD_DEBOUNCE_EN
   logic [15:0] prev_raw_q;
`endif

   // Two-flop synchronizer; preset to 1 so an absent pad reads as released.
   // NOTE: sequential state is always updated with non-blocking assignments
   // so every flop samples the pre-edge value of its neighbours.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], controller_data};
      end
   end

   assign data_s = sync_q[1];

   // Free-running frame-rate counter; wraps at POLL_DIV-1.
   // NOTE: the default assignment first keeps this block latch-free.
   always_comb begin
      poll_d = poll_q + 20'd1;
      if (!enable || poll_q == POLL_LAST) begin
         poll_d = '0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         poll_q <= '0;
      end else begin
         poll_q <= poll_d;
      end
   end

   // Frame sequencer. Every pad-facing output is a flop set on the edge that
   // enters the state, so outputs line up exactly with state residency.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         phase_q    <= '0;
         bit_q      <= '0;
         shift_q    <= 16'hFFFF;
         latch_q    <= 1'b0;
         clk_q      <= 1'b1;
         button_q   <= 16'h0000;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
`ifdef SNES_PAD_DEBOUNCE_EN
         prev_raw_q <= 16'h0000;
`endif
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // A wrap seen outside IDLE is simply lost, never queued.
               if (enable && poll_q == POLL_LAST) begin
                  state_q <= S_LATCH;
                  latch_q <= 1'b1;
                  busy_q  <= 1'b1;
                  phase_q <= '0;
               end
            end
            S_LATCH: begin
               if (phase_q == LATCH_LAST) begin
                  state_q <= S_GAP;
                  latch_q <= 1'b0;
                  phase_q <= '0;
               end else begin
                  phase_q <= phase_q + 17'd1;
               end
            end
            S_GAP: begin
               if (phase_q == DIV_LAST) begin
                  // Bit 0 is already on the line once the latch falls.
                  shift_q <= {data_s, shift_q[15:1]};
                  state_q <= S_LOW;
                  clk_q   <= 1'b0;
                  bit_q   <= 4'd1;
                  phase_q <= '0;
               end else begin
                  phase_q <= phase_q + 17'd1;
               end
            end
            S_LOW: begin
               if (phase_q == DIV_LAST) begin
                  state_q <= S_HIGH;
                  clk_q   <= 1'b1;
                  phase_q <= '0;
               end else begin
                  phase_q <= phase_q + 17'd1;
               end
            end
            S_HIGH: begin
               if (phase_q == DIV_LAST) begin
                  // Sample late in the high phase so the synchronizer has
                  // settled on the bit the pad shifted out on the rising edge.
                  shift_q <= {data_s, shift_q[15:1]};
                  phase_q <= '0;
                  if (bit_q == 4'd15) begin
                     state_q <= S_DONE;
                  end else begin
                     state_q <= S_LOW;
                     clk_q   <= 1'b0;
                     bit_q   <= bit_q + 4'd1;
                  end
               end else begin
                  phase_q <= phase_q + 17'd1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
`ifdef SNES_PAD_DEBOUNCE_EN
               if (~shift_q == prev_raw_q) begin
                  button_q <= ~shift_q;
                  valid_q  <= 1'b1;
               end
               prev_raw_q <= ~shift_q;
`else
               button_q <= ~shift_q;
               valid_q  <= 1'b1;
`endif
            end
            default: begin
               state_q <= S_IDLE;
               latch_q <= 1'b0;
               clk_q   <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign controller_clock = clk_q;
   assign controller_latch = latch_q;
   assign button_state     = button_q;
   assign state_valid      = valid_q;
   assign busy             = busy_q;

endmodule

// File: doc/snes_pad_reader.md
Name: snes_pad_reader

Overview:
Polls an SNES controller over the JB PMOD: drives latch/clock, serially captures 16 button bits, and presents a registered, active-high button vector to the downstream joypad mapping logic. Runs on the 33.33 MHz core clock with internal timing counters, so no divided clocks are needed. One frame is read every POLL_DIV cycles.

Parameters:
CLK_DIV, 200, core cycles per controller-clock half period (6 us at 33.33 MHz); legal range 4..65535
POLL_DIV, 555555, core cycles between frame starts (~60 Hz); must be >= 33*CLK_DIV+2; max 2^20

Ports:
clock  input  1  core clock (33.33 MHz)
reset_n  input  1  asynchronous, active-low reset
enable  input  1  polling enable; 0 holds poll counter at 0
controller_data  input  1  serial data from pad; active-low (0 = pressed)
controller_clock  output  1  pad shift clock; idles high
controller_latch  output  1  pad latch pulse; active-high
button_state  output  16  bit n = button n pressed (bit0 = B ... bit11 = R), registered
state_valid  output  1  one-cycle pulse when button_state is updated
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (async, reset_n=0): latch=0, clock=1, button_state=16'h0000, state_valid=0, busy=0, state=IDLE, poll and phase counters=0, shift register=16'hFFFF, 2-flop sync on controller_data preset to 1. Reset mid-frame aborts immediately; no partial update.
- controller_data passes through a 2-flop synchronizer; all sampling uses the synchronized value (2-cycle skew; CLK_DIV>=4 covers it).
- Poll counter: counts 0..POLL_DIV-1 and wraps while enable=1; held at 0 while enable=0.
- FSM (all outputs registered):
  IDLE: latch=0, clock=1. On poll counter == POLL_DIV-1 with enable=1 -> LATCH; latch is high on the next cycle.
  LATCH: latch=1 for exactly 2*CLK_DIV cycles -> GAP.
  GAP: latch=0, clock=1 for CLK_DIV cycles; sample bit 0 on the last cycle -> LOW.
  LOW: clock=0 for CLK_DIV cycles -> HIGH.
  HIGH: clock=1 for CLK_DIV cycles; sample bit n (n=1..15) on the last cycle; n==15 -> DONE, else -> LOW.
  DONE: one cycle: button_state <= ~shift, state_valid=1 -> IDLE.
- Frame length = 33*CLK_DIV+1 cycles; exactly 15 low pulses on controller_clock.
- Bit order: first sampled bit lands in button_state[0], last in [15].
- enable dropped mid-frame: frame completes and updates normally; no new frame starts.
- Poll wrap while not IDLE (parameter violation): ignored. The wrap is not queued.
- No controller (line pulled high): reads 16'h0000 (all released).

Optional Feature:
Macro SNES_PAD_DEBOUNCE_EN. When defined, the block holds the previous raw frame. In DONE, button_state is updated and state_valid pulses only if the new frame equals the previous raw frame; the previous raw frame is always updated. The previous raw frame resets to 16'h0000. When not defined, every completed frame updates button_state and pulses state_valid.

Test Plan (sim: CLK_DIV=4, POLL_DIV=200; pad BFM shifts on controller_clock rising edge, reloads on latch):
1. Assert reset_n=0 for 3 cycles, then release with enable=0 -> latch=0, clock=1, button_state=0x0000, state_valid=0, busy=0; no latch for 1000 cycles.
2. enable=1, BFM presents pressed=0xA5C3 -> latch high exactly 8 cycles; 15 clock lows of 4 cycles each; button_state=0xA5C3 with a single state_valid pulse 133 cycles after latch rise.
3. Continuous polling -> successive latch rising edges exactly 200 cycles apart; busy is high for 133 cycles per frame.
4. enable=0 during LOW of bit 5 -> frame completes (valid pulse seen); no further latch for 1000 cycles; re-enable -> next latch 200 cycles later.
5. reset_n=0 during HIGH of bit 7 -> outputs take reset values in the same cycle, button_state=0x0000; after release, a full 8-cycle latch starts a fresh frame.
6. Frames 0x0001, 0x0003, 0x0003 -> with SNES_PAD_DEBOUNCE_EN: button_state stays 0x0000, then 0x0000, then 0x0003, with valid only on the third frame. Without the macro: 0x0001, 0x0003, 0x0003, with valid on every frame.
